hyperram_port_arbiter: RTL



---
 rtl/hyperram_pkg.sv | 11 +
 rtl/hyperram_port_arbiter_if.sv | 29 ++
 rtl/hyperram_rr_pick.sv | 18 +
 rtl/hyperram_port_arbiter.sv | 91 +++++++++
 4 files changed

// File: rtl/hyperram_pkg.sv
// hyperram_pkg: shared types and constants for the HyperRAM port arbiter and controller
package hyperram_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, REJECT} state_t;
   localparam int WORD_W = 16;
   localparam int CA_RW_BIT = 47;
   localparam int CA_AS_BIT = 46;
   // a transaction of zero words or longer than the tCSM-bounded burst is refused
   function automatic logic len_bad(input int unsigned len, input int unsigned max_burst);
      return (len == 0) || (len > max_burst);
   endfunction
endpackage

// File: rtl/hyperram_port_arbiter_if.sv
// hyperram_port_arbiter_if: requester-side and controller-side bus of the port arbiter
interface hyperram_port_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W = 8
);
   import hyperram_pkg::*;
   logic [NUM_PORTS-1:0] p_req_valid, p_req_ready, p_req_wr, p_req_reg;
   logic [NUM_PORTS-1:0] p_wready, p_rvalid, p_done, p_err;
   logic [NUM_PORTS*ADDR_W-1:0] p_req_addr;
   logic [NUM_PORTS*LEN_W-1:0] p_req_len;
   logic [NUM_PORTS*WORD_W-1:0] p_wdata;
   logic [WORD_W-1:0] p_rdata, c_wdata, c_rdata;
   logic c_cmd_valid, c_cmd_ready, c_cmd_wr, c_cmd_reg, c_wready, c_rvalid, c_done;
   logic [ADDR_W-1:0] c_cmd_addr;
   logic [LEN_W-1:0] c_cmd_len;
   modport master (
      input p_req_valid, p_req_wr, p_req_reg, p_req_addr, p_req_len, p_wdata,
      input c_cmd_ready, c_wready, c_rdata, c_rvalid, c_done,
      output p_req_ready, p_wready, p_rdata, p_rvalid, p_done, p_err,
      output c_cmd_valid, c_cmd_wr, c_cmd_reg, c_cmd_addr, c_cmd_len, c_wdata
   );
   modport slave (
      output p_req_valid, p_req_wr, p_req_reg, p_req_addr, p_req_len, p_wdata,
      output c_cmd_ready, c_wready, c_rdata, c_rvalid, c_done,
      input p_req_ready, p_wready, p_rdata, p_rvalid, p_done, p_err,
      input c_cmd_valid, c_cmd_wr, c_cmd_reg, c_cmd_addr, c_cmd_len, c_wdata
   );
endinterface

// File: rtl/hyperram_rr_pick.sv
// hyperram_rr_pick: combinational round-robin picker, first requester after last
module hyperram_rr_pick #(
   parameter int NUM_PORTS = 4,
   localparam int IW = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IW-1:0]        last,
   output logic [IW-1:0]        grant_idx,
   output logic                 any
);
   // scan from farthest to nearest so the port closest after last wins
   always_comb begin
      grant_idx = '0;
      any = |req;
      for (int i = NUM_PORTS; i >= 1; i--)
         if (req[(int'(last) + i) % NUM_PORTS]) grant_idx = IW'((int'(last) + i) % NUM_PORTS);
   end
endmodule

// File: rtl/hyperram_port_arbiter.sv
// hyperram_port_arbiter: round-robin sharing of one HyperRAM controller between requesters
module hyperram_port_arbiter
   import hyperram_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int ADDR_W = 32,
   parameter int LEN_W = 8,
   parameter int MAX_BURST = 128
) (
   input logic clk,
   input logic rst,
   hyperram_port_arbiter_if.master bus
);
   localparam int IW = $clog2(NUM_PORTS);
   state_t state, state_nxt;
   logic [IW-1:0] last_grant, grant, pick;
   logic any, cmd_wr, cmd_reg, beat, busy, fin;
   logic [ADDR_W-1:0] cmd_addr, sel_addr;
   logic [LEN_W-1:0] cmd_len, sel_len, cnt, cnt_nxt;
   logic [NUM_PORTS-1:0] onehot;

   hyperram_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
      .req(bus.p_req_valid),
      .last(last_grant),
      .grant_idx(pick),
      .any(any)
   );

   assign sel_addr = bus.p_req_addr[int'(pick)*ADDR_W +: ADDR_W];
   assign sel_len = bus.p_req_len[int'(pick)*LEN_W +: LEN_W];
   assign busy = state == BUSY;
   assign fin = busy && bus.c_done;
   assign beat = cmd_wr ? bus.c_wready : bus.c_rvalid;
   assign cnt_nxt = cnt + LEN_W'(beat);
   assign onehot = NUM_PORTS'(1) << grant;

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;

   // next-state: one whole transaction per grant, no preemption
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = !any ? IDLE : len_bad(int'(sel_len), MAX_BURST) ? REJECT : ISSUE;
         ISSUE:   state_nxt = bus.c_cmd_ready ? BUSY : ISSUE;
         BUSY:    state_nxt = bus.c_done ? IDLE : BUSY;
         default: state_nxt = IDLE;
      endcase
   end

   // command latch, beat counter and round-robin pointer
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         last_grant <= IW'(NUM_PORTS - 1);
         grant <= '0;
         cmd_wr <= 1'b0;
         cmd_reg <= 1'b0;
         cmd_addr <= '0;
         cmd_len <= '0;
         cnt <= '0;
      end else begin
         if (state == IDLE && any) begin
            grant <= pick;
            cmd_wr <= bus.p_req_wr[pick];
            cmd_reg <= bus.p_req_reg[pick];
            cmd_addr <= sel_addr;
            cmd_len <= sel_len;
         end
         if (state == ISSUE && bus.c_cmd_ready) cnt <= '0;
         else if (busy) cnt <= cnt_nxt;
         if (fin || state == REJECT) last_grant <= grant;
      end

   // outputs: command fields from latches, data and status steered to the granted port
   always_comb begin
      bus.c_cmd_valid = state == ISSUE;
      bus.c_cmd_wr = cmd_wr;
      bus.c_cmd_reg = cmd_reg;
      bus.c_cmd_addr = cmd_addr;
      bus.c_cmd_len = cmd_len;
      bus.c_wdata = busy ? bus.p_wdata[int'(grant)*WORD_W +: WORD_W] : '0;
      bus.p_rdata = busy ? bus.c_rdata : '0;
      bus.p_req_ready = ((state == ISSUE && bus.c_cmd_ready) || state == REJECT) ? onehot : '0;
      bus.p_wready = (busy && cmd_wr && bus.c_wready) ? onehot : '0;
      bus.p_rvalid = (busy && !cmd_wr && bus.c_rvalid) ? onehot : '0;
      bus.p_done = (fin || state == REJECT) ? onehot : '0;
      bus.p_err = ((fin && cnt_nxt != cmd_len) || state == REJECT) ? onehot : '0;
   end
endmodule
